// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues single-outstanding word fetches for pc_in, buffers tagged responses
// in a DEPTH-entry FIFO for decode, and computes pc_next. Optional IFQ_BYPASS_EN forwards empty-queue responses.
module ifetch_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  output logic [AW-1:0] pc_next,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [31:0]   data_mem_r [DEPTH];
  logic [AW-1:0] pc_mem_r   [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] req_pc_r;

  logic fifo_valid_s;
  logic rsp_s;
  logic bypass_s;
  logic push_s;
  logic pop_s;
  logic req_s;
  logic fire_s;

  assign fifo_valid_s = (count_r != {CW{1'b0}});
  // Only WAIT owns a live response; IDLE and DROP ignore rvalid.
  assign rsp_s        = (state_r == WAIT) && imem_rvalid && !redirect_valid;
`ifdef IFQ_BYPASS_EN
  assign bypass_s     = rsp_s && !fifo_valid_s;
`else
  assign bypass_s     = 1'b0;
`endif
  assign push_s       = rsp_s && !(bypass_s && inst_ready);
  assign pop_s        = fifo_valid_s && inst_ready;
  assign req_s        = (state_r == IDLE) && (count_r < DEPTH_C) && !redirect_valid && !reset;
  assign fire_s       = req_s && imem_gnt;

  assign imem_req   = req_s;
  assign imem_addr  = pc_in;
  assign inst_valid = fifo_valid_s || bypass_s;
  assign inst_data  = bypass_s ? imem_rdata : data_mem_r[rd_ptr_r];
  assign inst_pc    = bypass_s ? req_pc_r   : pc_mem_r[rd_ptr_r];

  // PC loop: redirect beats advance, advance beats hold.
  always_comb begin
    pc_next = pc_in;
    if (reset) begin
      pc_next = {AW{1'b0}};
    end else if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (fire_s) begin
      pc_next = pc_in + AW'(4);
    end else begin
      pc_next = pc_in;
    end
  end

  // Fetch FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (fire_s) state_nx_s = WAIT;
        else        state_nx_s = IDLE;
      end
      WAIT: begin
        if (redirect_valid) state_nx_s = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) state_nx_s = IDLE;
        else state_nx_s = WAIT;
      end
      DROP: begin
        if (imem_rvalid) state_nx_s = IDLE;
        else             state_nx_s = DROP;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state, request tag, and FIFO pointers/occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      req_pc_r <= {AW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (fire_s) req_pc_r <= pc_in;
      if (redirect_valid) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
        count_r  <= {CW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // FIFO storage; the credit rule guarantees a free slot on every push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]   <= req_pc_r;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: cycle vector table plus directed redirect/wrap/reset sequences,
// with a PC-ordered scoreboard checking every decode handshake.
module tb_ifetch_queue;
  localparam int AW    = 32;
  localparam int DEPTH = 2;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [AW-1:0] pc_in;
  logic [AW-1:0] pc_next;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_data;
  logic [AW-1:0] inst_pc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] exp_q [$];

  typedef struct {
    logic        rst_b;
    logic        gnt;
    logic        rv;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_pcn;
    logic        e_val;
    logic [31:0] e_ipc;
  } vec_t;
  vec_t tbl [$];

  ifetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the upstream PC register, with a load port for corner cases.
  always @(posedge clk or posedge reset) begin
    if (reset)        pc_in <= '0;
    else if (pc_load) pc_in <= pc_load_val;
    else              pc_in <= pc_next;
  end

  function automatic logic [31:0] fdat(input logic [31:0] pc);
    return 32'h20080005 ^ pc;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: a grant pushes its PC, a redirect or reset kills everything in flight.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got pc %08h with no expected entry at %0t", inst_pc, $time);
        end else begin
          chk("sb_pc", inst_pc, exp_q[0]);
          chk("sb_data", inst_data, fdat(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (redirect_valid) exp_q.delete();
      if (imem_req && imem_gnt) exp_q.push_back(pc_in);
    end
  end

  task automatic add(input logic r, input logic g, input logic v, input logic y, input logic [31:0] d,
                     input logic er, input logic [31:0] ep, input logic ev, input logic [31:0] ei);
    vec_t e;
    e.rst_b = r; e.gnt = g; e.rv = v; e.rdy = y; e.rdata = d;
    e.e_req = er; e.e_pcn = ep; e.e_val = ev; e.e_ipc = ei;
    tbl.push_back(e);
  endtask

  task automatic drive(input logic g, input logic v, input logic [31:0] d, input logic y,
                       input logic rdv, input logic [31:0] rdpc);
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    imem_gnt = g; imem_rvalid = v; imem_rdata = d; inst_ready = y;
    redirect_valid = rdv; redirect_pc = rdpc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    pc_load = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_pcnext", pc_next, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pc_load = 1'b0; pc_load_val = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #12;

    // Single fetch, latency 1, decode always ready.
    add(1'b1, 1'b1, 1'b0, 1'b1, 32'd0,      1'b1, 32'd4,  1'b0, 32'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, fdat(0),    1'b0, 32'd4,  BYP,  32'd0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'd0,      1'b1, 32'd4,  !BYP, 32'd0);
    // Decode stalled: queue fills with PCs 0 and 4, then drains in order and fetch resumes at 8.
    add(1'b1, 1'b1, 1'b1, 1'b0, 32'd0,      1'b1, 32'd4,  1'b0, 32'd0);
    add(1'b0, 1'b1, 1'b1, 1'b0, fdat(0),    1'b0, 32'd4,  BYP,  32'd0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 32'd0,      1'b1, 32'd8,  1'b1, 32'd0);
    add(1'b0, 1'b1, 1'b1, 1'b0, fdat(4),    1'b0, 32'd8,  1'b1, 32'd0);
    for (int i = 0; i < 6; i++)
      add(1'b0, 1'b1, 1'b1, 1'b0, 32'd0,    1'b0, 32'd8,  1'b1, 32'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'd0,      1'b0, 32'd8,  1'b1, 32'd0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'd0,      1'b1, 32'd12, 1'b1, 32'd4);
    add(1'b0, 1'b1, 1'b1, 1'b1, fdat(8),    1'b0, 32'd12, BYP,  32'd8);
    add(1'b0, 1'b0, 1'b0, 1'b1, 32'd0,      1'b1, 32'd12, !BYP, 32'd8);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_b) do_reset();
      drive(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy, 1'b0, 32'd0);
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("v%0d_pcnext", i), pc_next, tbl[i].e_pcn);
      chk($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_val});
      if (tbl[i].e_val) chk($sformatf("v%0d_ipc", i), inst_pc, tbl[i].e_ipc);
    end

    // Redirect while waiting; stale response arrives three cycles later and is dropped.
    do_reset();
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h100);
    chk("rdw_pcnext", pc_next, 32'h100);
    chk("rdw_req", {31'd0, imem_req}, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("drop_req", {31'd0, imem_req}, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 32'hBAD0BAD0, 1'b1, 1'b0, 32'd0);
    chk("drop_valid", {31'd0, inst_valid}, 32'd0);
    chk("drop_pcnext", pc_next, 32'h100);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("rdw_addr", imem_addr, 32'h100);
    chk("rdw_grant_pcnext", pc_next, 32'h104);
    drive(1'b0, 1'b1, fdat(32'h100), 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("rdw_empty", {31'd0, inst_valid}, 32'd0);

    // Redirect coincident with a response while one entry is queued.
    do_reset();
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, fdat(0), 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("rdr_grant_pcnext", pc_next, 32'd8);
    drive(1'b0, 1'b1, fdat(4), 1'b0, 1'b1, 32'h200);
    chk("rdr_pcnext", pc_next, 32'h200);
    chk("rdr_valid_before", {31'd0, inst_valid}, 32'd1);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("rdr_valid_after", {31'd0, inst_valid}, 32'd0);
    chk("rdr_idle_req", {31'd0, imem_req}, 32'd1);
    chk("rdr_addr", imem_addr, 32'h200);

    // PC wrap at the top of the address space.
    do_reset();
    @(posedge clk);
    #1;
    pc_load_val = 32'hFFFFFFFC;
    pc_load = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
    chk("wrap_pcnext", pc_next, 32'd0);
    drive(1'b0, 1'b1, fdat(32'hFFFFFFFC), 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("wrap_hold", pc_next, 32'd0);

    // Asynchronous reset mid-WAIT with an entry queued, then a stray response.
    do_reset();
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, fdat(0), 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    imem_gnt = 1'b0;
    chk("arst_valid_before", {31'd0, inst_valid}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_pcnext", pc_next, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0);
    chk("stray_valid", {31'd0, inst_valid}, 32'd0);
    chk("stray_req", {31'd0, imem_req}, 32'd1);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("stray_valid_after", {31'd0, inst_valid}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
